// File: rtl/ps2_device_port.sv
// PS/2 device-side port: sends scan-code bytes to the host and receives command
// bytes from it. The device always generates the PS/2 clock. Both lines are
// open-drain, so the port only ever pulls them low or releases them.
module ps2_device_port #(
    parameter int CLK_HALF    = 2500,
    parameter int IDLE_CYCLES = 2500,
    parameter int RTS_DELAY   = 2500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

    localparam int MAX_A   = (CLK_HALF > IDLE_CYCLES) ? CLK_HALF : IDLE_CYCLES;
    localparam int MAX_CYC = (MAX_A > RTS_DELAY) ? MAX_A : RTS_DELAY;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] HALF_LAST   = CW'(CLK_HALF - 1);
    localparam logic [CW-1:0] RTS_LAST    = CW'(RTS_DELAY - 1);
    localparam logic [CW-1:0] IDLE_MAX    = CW'(IDLE_CYCLES);
    localparam logic [CW-1:0] INHIBIT_MIN = CW'(3);
    localparam logic [3:0]    TX_STOP_BIT = 4'd10;
    localparam logic [3:0]    RX_STOP_BIT = 4'd9;

    typedef enum logic [3:0] {
        IDLE,
        TX_BIT_LOW,
        TX_BIT_HIGH,
        TX_HOLDOFF,
        RX_WAIT,
        RX_LOW,
        RX_HIGH,
        RX_ACK_LOW,
        RX_ACK_HIGH
    } state_t;

    state_t        state;
    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_s;
    logic          dat_s;
    logic          clk_meta;
    logic          dat_meta;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idle_cnt;
    logic [3:0]    bit_cnt;
    logic [3:0]    next_bit;
    logic          held;
    logic [7:0]    tx_byte;
    logic [10:0]   tx_frame;
    logic [8:0]    rx_shift;
    logic          clk_low;
    logic          dat_low;

    assign clk_meta = clk_sync[0];
    assign dat_meta = dat_sync[0];
    assign clk_s    = clk_sync[1];
    assign dat_s    = dat_sync[1];
    assign next_bit = bit_cnt + 4'd1;
    assign tx_frame = {1'b1, ~^tx_byte, tx_byte, 1'b0};
    assign busy     = (state != IDLE);
    assign PS2_CLK  = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT  = dat_low ? 1'b0 : 1'bz;

    // Two-flop synchronizers on both lines; they rest high like the pulled-up bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
        end
    end

    // Protocol FSM: line drivers, bit/phase counters, byte holding and status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idle_cnt <= '0;
            bit_cnt  <= '0;
            held     <= 1'b0;
            tx_byte  <= '0;
            rx_shift <= '0;
            clk_low  <= 1'b0;
            dat_low  <= 1'b0;
            tx_ready <= 1'b0;
            tx_done  <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_data  <= '0;
        end else begin
            tx_ready <= 1'b0;
            tx_done  <= 1'b0;
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    clk_low <= 1'b0;
                    dat_low <= 1'b0;
                    if (clk_s && dat_s) begin
                        if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
                    end else begin
                        idle_cnt <= '0;
                    end
                    if (clk_s && !dat_s) begin
                        state    <= RX_WAIT;
                        cnt      <= '0;
                        idle_cnt <= '0;
                    end else if (held && idle_cnt == IDLE_MAX) begin
                        state    <= TX_BIT_HIGH;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        idle_cnt <= '0;
                        dat_low  <= ~tx_frame[0];
                    end else begin
                        if (tx_valid && tx_ready) begin
                            held    <= 1'b1;
                            tx_byte <= tx_data;
                        end
                        // The first sync stage predicts next cycle's line view, so
                        // ready is never offered into an RTS.
                        tx_ready <= !held && !(tx_valid && tx_ready) && !(clk_meta && !dat_meta);
                    end
                end
                TX_BIT_HIGH: begin
                    if (!clk_s && cnt >= INHIBIT_MIN && bit_cnt != TX_STOP_BIT) begin
                        state   <= TX_HOLDOFF;
                        clk_low <= 1'b0;
                        dat_low <= 1'b0;
                        cnt     <= '0;
                    end else if (cnt == HALF_LAST) begin
                        state   <= TX_BIT_LOW;
                        clk_low <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_BIT_LOW: begin
                    if (cnt == HALF_LAST) begin
                        clk_low <= 1'b0;
                        cnt     <= '0;
                        if (bit_cnt == TX_STOP_BIT) begin
                            state    <= IDLE;
                            dat_low  <= 1'b0;
                            held     <= 1'b0;
                            tx_done  <= 1'b1;
                            idle_cnt <= '0;
                        end else begin
                            state   <= TX_BIT_HIGH;
                            bit_cnt <= next_bit;
                            dat_low <= ~tx_frame[next_bit];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_HOLDOFF: begin
                    clk_low <= 1'b0;
                    dat_low <= 1'b0;
                    if (clk_s) begin
                        state    <= IDLE;
                        idle_cnt <= '0;
                    end
                end
                RX_WAIT: begin
                    if (cnt == RTS_LAST) begin
                        state   <= RX_LOW;
                        clk_low <= 1'b1;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_LOW: begin
                    if (cnt == HALF_LAST) begin
                        state   <= RX_HIGH;
                        clk_low <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_HIGH: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!clk_s) begin
                            state    <= IDLE;
                            clk_low  <= 1'b0;
                            dat_low  <= 1'b0;
                            idle_cnt <= '0;
                        end else if (bit_cnt == RX_STOP_BIT) begin
                            if ((^rx_shift) && dat_s) begin
                                state   <= RX_ACK_LOW;
                                clk_low <= 1'b1;
                                dat_low <= 1'b1;
                            end else begin
                                state    <= IDLE;
                                rx_valid <= 1'b1;
                                rx_err   <= 1'b1;
                                rx_data  <= rx_shift[7:0];
                                idle_cnt <= '0;
                            end
                        end else begin
                            rx_shift <= {dat_s, rx_shift[8:1]};
                            bit_cnt  <= next_bit;
                            state    <= RX_LOW;
                            clk_low  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_ACK_LOW: begin
                    // Data is let go at the end of the ACK low phase so the synced
                    // line is high again before IDLE looks for a new RTS.
                    if (cnt == HALF_LAST) begin
                        state   <= RX_ACK_HIGH;
                        clk_low <= 1'b0;
                        dat_low <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_ACK_HIGH: begin
                    if (cnt == HALF_LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        rx_valid <= 1'b1;
                        rx_err   <= 1'b0;
                        rx_data  <= rx_shift[7:0];
                        idle_cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    clk_low <= 1'b0;
                    dat_low <= 1'b0;
                end
            endcase
        end
    end

endmodule
